// File: rtl/order_ingress_arbiter_if.sv
// order_ingress_arbiter_if: CPU/exchange push side and downstream request side.
// Ports: cpu_in_* / exch_in_* push handshakes, cpu_* / exchange_* go requests, busy.
interface order_ingress_arbiter_if;
   logic        cpu_in_valid;
   logic        cpu_in_ready;
   logic [4:0]  cpu_in_id;
   logic [31:0] cpu_in_amount;
   logic        cpu_in_is_max;
   logic        exch_in_valid;
   logic        exch_in_ready;
   logic [4:0]  exch_in_id;
   logic [15:0] exch_in_amount;
   logic [4:0]  cpu_client_id;
   logic [31:0] cpu_amount;
   logic        cpu_new_max;
   logic        cpu_go;
   logic [4:0]  exchange_client_id;
   logic [15:0] exchange_amount;
   logic        exchange_go;
   logic        busy;

   modport slave (
      input  cpu_in_valid, cpu_in_id, cpu_in_amount, cpu_in_is_max,
      input  exch_in_valid, exch_in_id, exch_in_amount,
      output cpu_in_ready, exch_in_ready,
      output cpu_client_id, cpu_amount, cpu_new_max, cpu_go,
      output exchange_client_id, exchange_amount, exchange_go, busy
   );

   modport master (
      output cpu_in_valid, cpu_in_id, cpu_in_amount, cpu_in_is_max,
      output exch_in_valid, exch_in_id, exch_in_amount,
      input  cpu_in_ready, exch_in_ready,
      input  cpu_client_id, cpu_amount, cpu_new_max, cpu_go,
      input  exchange_client_id, exchange_amount, exchange_go, busy
   );
endinterface

// File: rtl/order_ingress_arbiter.sv
// order_ingress_arbiter: buffers CPU and exchange requests in two FIFOs and
// issues one single-cycle go pulse at a time, followed by an idle gap.
// Ports: clk, HRESETn (async, active-low), bus (order_ingress_arbiter_if.slave).
module order_ingress_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int STARVE_LIMIT = 3
) (
   input logic                          clk,
   input logic                          HRESETn,
   order_ingress_arbiter_if.slave       bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_GAP
   } state_t;

   logic [4:0]    r_cq_id  [FIFO_DEPTH];
   logic [31:0]   r_cq_amt [FIFO_DEPTH];
   logic          r_cq_max [FIFO_DEPTH];
   logic [4:0]    r_eq_id  [FIFO_DEPTH];
   logic [15:0]   r_eq_amt [FIFO_DEPTH];

   logic [PW-1:0] r_cwp, r_crp, r_ewp, r_erp;

   state_t        r_state;
   logic [GW-1:0] r_gap;
   logic [SW-1:0] r_starve;

   logic [4:0]    r_cpu_id;
   logic [31:0]   r_cpu_amt;
   logic          r_cpu_max;
   logic          r_cpu_go;
   logic [4:0]    r_ex_id;
   logic [15:0]   r_ex_amt;
   logic          r_ex_go;
   logic          r_busy;

   logic          w_c_empty, w_c_full, w_c_push;
   logic          w_e_empty, w_e_full, w_e_push;
   logic          w_pick_e, w_pick_c;

   // Extra pointer MSB separates full (MSBs differ) from empty (equal).
   assign w_c_empty = (r_cwp == r_crp);
   assign w_c_full  = (r_cwp[AW] != r_crp[AW]) &&
                      (r_cwp[AW-1:0] == r_crp[AW-1:0]);
   assign w_e_empty = (r_ewp == r_erp);
   assign w_e_full  = (r_ewp[AW] != r_erp[AW]) &&
                      (r_ewp[AW-1:0] == r_erp[AW-1:0]);

   assign w_c_push = bus.cpu_in_valid & ~w_c_full;
   assign w_e_push = bus.exch_in_valid & ~w_e_full;

   // Exchange wins unless a waiting CPU entry has hit the starvation limit.
   assign w_pick_e = (r_state == S_IDLE) & ~w_e_empty &
                     (w_c_empty | (r_starve < SW'(STARVE_LIMIT)));
   assign w_pick_c = (r_state == S_IDLE) & ~w_c_empty & ~w_pick_e;

   // Storage needs no reset; pointers alone define occupancy.
   always_ff @(posedge clk) begin
      if (w_c_push) begin
         r_cq_id[r_cwp[AW-1:0]]  <= bus.cpu_in_id;
         r_cq_amt[r_cwp[AW-1:0]] <= bus.cpu_in_amount;
         r_cq_max[r_cwp[AW-1:0]] <= bus.cpu_in_is_max;
      end
      if (w_e_push) begin
         r_eq_id[r_ewp[AW-1:0]]  <= bus.exch_in_id;
         r_eq_amt[r_ewp[AW-1:0]] <= bus.exch_in_amount;
      end
   end

   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         r_cwp <= '0;
         r_ewp <= '0;
      end else begin
         if (w_c_push) r_cwp <= r_cwp + 1'b1;
         if (w_e_push) r_ewp <= r_ewp + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state   <= S_IDLE;
         r_gap     <= '0;
         r_starve  <= '0;
         r_crp     <= '0;
         r_erp     <= '0;
         r_cpu_id  <= '0;
         r_cpu_amt <= '0;
         r_cpu_max <= 1'b0;
         r_cpu_go  <= 1'b0;
         r_ex_id   <= '0;
         r_ex_amt  <= '0;
         r_ex_go   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               unique case (1'b1)
                  w_pick_e: begin
                     r_ex_id  <= r_eq_id[r_erp[AW-1:0]];
                     r_ex_amt <= r_eq_amt[r_erp[AW-1:0]];
                     r_erp    <= r_erp + 1'b1;
                     r_ex_go  <= 1'b1;
                     r_busy   <= 1'b1;
                     r_state  <= S_ISSUE;
                     if (w_c_empty)
                        r_starve <= '0;
                     else if (r_starve != SW'(STARVE_LIMIT))
                        r_starve <= r_starve + 1'b1;
                  end
                  w_pick_c: begin
                     r_cpu_id  <= r_cq_id[r_crp[AW-1:0]];
                     r_cpu_amt <= r_cq_amt[r_crp[AW-1:0]];
                     r_cpu_max <= r_cq_max[r_crp[AW-1:0]];
                     r_crp     <= r_crp + 1'b1;
                     r_cpu_go  <= 1'b1;
                     r_busy    <= 1'b1;
                     r_starve  <= '0;
                     r_state   <= S_ISSUE;
                  end
                  default: ;
               endcase
            end
            S_ISSUE: begin
               r_cpu_go <= 1'b0;
               r_ex_go  <= 1'b0;
               r_gap    <= GW'(GAP_CYCLES - 1);
               r_state  <= S_GAP;
            end
            S_GAP: begin
               if (r_gap == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_gap <= r_gap - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cpu_in_ready       = ~w_c_full;
   assign bus.exch_in_ready      = ~w_e_full;
   assign bus.cpu_client_id      = r_cpu_id;
   assign bus.cpu_amount         = r_cpu_amt;
   assign bus.cpu_new_max        = r_cpu_max;
   assign bus.cpu_go             = r_cpu_go;
   assign bus.exchange_client_id = r_ex_id;
   assign bus.exchange_amount    = r_ex_amt;
   assign bus.exchange_go        = r_ex_go;
   assign bus.busy               = r_busy;

endmodule

// File: doc/order_ingress_arbiter.md
# order_ingress_arbiter

Front-end stage that feeds the order/risk top level. It buffers CPU order and max-limit requests and exchange fill reports in two independent FIFOs, and arbitrates between them. It issues exactly one request at a time onto the top level's `cpu_*` / `exchange_*` inputs as a single-cycle go pulse, followed by a mandatory idle gap, so that the downstream change-sensitive request logic sees clean, non-overlapping edges. Exchange fills have priority, and a starvation limit guarantees CPU progress.

## Interface
- `FIFO_DEPTH`, 4: entries per FIFO; power of two, at least 2.
- `GAP_CYCLES`, 2: idle cycles after each go pulse, at least 1.
- `STARVE_LIMIT`, 3: consecutive exchange issues allowed while a CPU entry waits.
- `clk` in 1: single clock; all state is on the rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `cpu_in_valid` in 1: CPU request offered.
- `cpu_in_ready` out 1: CPU FIFO not full.
- `cpu_in_id` in 5: client id.
- `cpu_in_amount` in 32: order amount or new max.
- `cpu_in_is_max` in 1: 1 = max update, 0 = new order.
- `exch_in_valid` in 1: fill offered.
- `exch_in_ready` out 1: exchange FIFO not full.
- `exch_in_id` in 5: client id.
- `exch_in_amount` in 16: filled/cancelled amount.
- `cpu_client_id` out 5, `cpu_amount` out 32, `cpu_new_max` out 1, `cpu_go` out 1: CPU request to downstream.
- `exchange_client_id` out 5, `exchange_amount` out 16, `exchange_go` out 1: exchange request to downstream.
- `busy` out 1: state is not IDLE.

## Operation
- **Push:**
  - An entry is written when `*_in_valid & *_in_ready` is true on a clock edge.
  - `*_in_ready = !full`, and is computed from registered state only.
  - Valid while not ready is ignored; there is no drop and no overwrite.
- **FIFOs:**
  - Circular buffers with pointers of log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2·FIFO_DEPTH.
- **FSM:** IDLE → ISSUE → GAP → IDLE.
  - **IDLE:** if any FIFO is non-empty, select a source, pop its head into the output registers for that source, and go to ISSUE.
  - **ISSUE:** lasts exactly one cycle. The selected `*_go` = 1. Go to GAP.
  - **GAP:** lasts GAP_CYCLES cycles. Both go outputs = 0. A down-counter loads GAP_CYCLES−1; at 0, go to IDLE.
- **Arbitration (evaluated in IDLE):**
  - Exchange wins if it is non-empty and (CPU is empty or `starve_cnt` < STARVE_LIMIT). Otherwise CPU wins.
  - `starve_cnt` increments on an exchange issue while CPU is non-empty, saturating at STARVE_LIMIT.
  - `starve_cnt` clears on a CPU issue, or on an exchange issue when CPU is empty.
- **Outputs:**
  - Data outputs of a source are loaded only when that source is popped. They hold their value through ISSUE, GAP and subsequent cycles until that source's next pop.
  - `cpu_new_max` is registered together with the CPU data.
  - `cpu_go` and `exchange_go` are never 1 in the same cycle.
- **Simultaneous push and pop** on the same FIFO is legal.
  - When full, a pop does not make `in_ready` high in the same cycle; ready rises the cycle after the pop.
- **Reset:**
  - All outputs = 0, FIFOs empty, state = IDLE, `starve_cnt` = 0.
  - `in_ready` = 1 during and after reset.
  - Reset asserted mid-ISSUE or mid-GAP aborts immediately and discards all FIFO contents.

## Timing
- **Latency:** push at edge N into an empty FIFO with the FSM idle → go = 1 during cycle N+2. The pop edge is N+1, and the outputs are registered.
- **Throughput:** one request per 1+GAP_CYCLES+1 cycles (IDLE, ISSUE, GAP); 4 cycles at the defaults.
- `busy` is high from the cycle after a pop until the IDLE state is re-entered.
- All outputs are registers; no combinational path from inputs to outputs except none. `in_ready` is derived from pointers only.

## Test plan
- **Reset:**
  - Stimulus: hold HRESETn = 0 for 3 cycles, then release.
  - Required: all go/data outputs = 0; `cpu_in_ready` = `exch_in_ready` = 1; `busy` = 0.
- **Single CPU order:**
  - Stimulus: id = 3, amount = 0x64, is_max = 0, pushed at edge N.
  - Required: `cpu_go` = 1 only in cycle N+2, with `cpu_client_id` = 3, `cpu_amount` = 0x64, `cpu_new_max` = 0; 2 idle cycles follow; outputs remain held afterwards.
- **Priority:**
  - Stimulus: push CPU (id 1) and exchange (id 2, amount 0x10) in the same cycle.
  - Required: `exchange_go` is issued first, then `cpu_go` 4 cycles later; the two go signals never overlap.
- **Starvation:**
  - Stimulus: fill the exchange FIFO with 4 entries and push 1 CPU entry.
  - Required: issue order is E, E, E, C, E.
- **Full backpressure:**
  - Stimulus: push 5 CPU entries back-to-back with the FSM busy.
  - Required: `cpu_in_ready` = 0 after the 4th push; the 5th entry is not accepted until ready returns; all 5 are eventually issued in FIFO order with no loss.
- **Reset mid-GAP:**
  - Stimulus: 3 entries queued; assert HRESETn = 0 during GAP.
  - Required: outputs zero immediately; after release, nothing is issued and `busy` = 0.
